// File: rtl/argon_regfile_seq.sv
// Access sequencer for the Argon register file: reads rA and rB, hands the operands
// to execute, waits for the result with a timeout, and optionally writes it to rC.
module argon_regfile_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [3:0]  i_rA,
    input  logic [3:0]  i_rB,
    input  logic [3:0]  i_rC,
    input  logic        i_wr_en,
    output logic [15:0] o_bus_data,
    output logic        o_bus_drive,
    input  logic [15:0] i_rf_data,
    output logic        o_rf_selectLatch,
    output logic        o_rf_outputA,
    output logic        o_rf_outputB,
    output logic        o_rf_latchC,
    output logic [15:0] o_opA,
    output logic [15:0] o_opB,
    output logic        o_exec_valid,
    input  logic        i_result_valid,
    input  logic [15:0] i_result,
    output logic        o_done,
    output logic        o_error
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, SELECT, READ_A, READ_B, CAPT_B, EXEC, WRITE, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ra_q, rb_q, rc_q;
    logic        wr_en_q;
    logic [15:0] opa_q, opb_q, result_q;
    logic [CW-1:0] cnt_q;
    logic        err_q;
    logic        timeout;

    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_req_valid) state_d = SELECT;
            SELECT:  state_d = READ_A;
            READ_A:  state_d = READ_B;
            READ_B:  state_d = CAPT_B;
            CAPT_B:  state_d = EXEC;
            EXEC: begin
                // A result arriving in the timeout cycle still wins.
                if (i_result_valid) state_d = wr_en_q ? WRITE : DONE;
                else if (timeout)   state_d = DONE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            wr_en_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (i_req_valid) begin
                    ra_q    <= i_rA;
                    rb_q    <= i_rB;
                    rc_q    <= i_rC;
                    wr_en_q <= i_wr_en;
                    err_q   <= 1'b0;
                end
                READ_B: opa_q <= i_rf_data;
                CAPT_B: begin
                    opb_q <= i_rf_data;
                    cnt_q <= '0;
                end
                EXEC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (i_result_valid) result_q <= i_result;
                    else if (timeout)   err_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default first so no latch is inferred for unlisted states.
    always_comb begin
        o_req_ready      = 1'b0;
        o_bus_drive      = 1'b0;
        o_bus_data       = '0;
        o_rf_selectLatch = 1'b0;
        o_rf_outputA     = 1'b0;
        o_rf_outputB     = 1'b0;
        o_rf_latchC      = 1'b0;
        o_exec_valid     = 1'b0;
        o_done           = 1'b0;
        o_error          = 1'b0;
        unique case (state_q)
            IDLE:   o_req_ready = 1'b1;
            SELECT: begin
                o_bus_drive      = 1'b1;
                o_bus_data       = {4'h0, rc_q, rb_q, ra_q};
                o_rf_selectLatch = 1'b1;
            end
            READ_A: o_rf_outputA = 1'b1;
            READ_B: o_rf_outputB = 1'b1;
            EXEC:   o_exec_valid = 1'b1;
            WRITE: begin
                o_bus_drive = 1'b1;
                o_bus_data  = result_q;
                o_rf_latchC = 1'b1;
            end
            DONE: begin
                o_done  = 1'b1;
                o_error = err_q;
            end
            default: ;
        endcase
    end

    assign o_opA = opa_q;
    assign o_opB = opb_q;

endmodule
